result_drain: RTL and testbench

- Downstream stage of the matrix-multiply controller. Drains one 32-value result slot from the result RAM to the host over a valid/ready stream.
- Host posts a slot request. The block fires a one-cycle `read` pulse with the slot address at the controller, then captures the 32 values that appear on the RAM read port.
- Values are buffered in a FIFO so host back-pressure never stalls the controller's fixed 32-cycle read sequence.

---
 rtl/result_drain_pkg.sv | 28 ++
 rtl/result_fifo.sv | 57 +++++
 rtl/result_drain.sv | 134 +++++++++++++
 tb/tb_result_drain.sv | 377 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_drain_pkg.sv
// Shared types and helpers for the result drain stage.
// RESULT_DRAIN_SAT_EN selects saturation instead of truncation.
package result_drain_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } state_t;

  localparam int VALS_PER_SLOT = 32;
  localparam int SLOT_AW       = 5;

  // Clamp a sign-extended value to the signed range of out_w bits.
  function automatic logic [63:0] saturate(
    input logic signed [63:0] v,
    input int                 out_w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO with occupancy-derived full/empty/free outputs.
// Read data is combinational from the head entry.
module result_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             wr;
  logic             rd;

  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign full  = (count == CAP);
  assign empty = (count == '0);
  assign free  = CAP - count;
  assign rdata = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wdata;
  end

  // Space is reserved at request accept, so this must never fire.
  always_ff @(posedge clk) begin
    if (rst_n && push)
      assert (!full) else $error("result_fifo: push while full");
  end

endmodule

// File: rtl/result_drain.sv
// Drains one 32-value result slot from the result RAM to a host stream.
// Define RESULT_DRAIN_SAT_EN to saturate values instead of truncating.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int OUT_W      = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [SLOT_AW-1:0]  req_slot,
  input  logic                calc_start,
  input  logic                calc_finish,
  output logic                read,
  output logic [SLOT_AW-1:0]  rd_addr,
  input  logic                sel_upper,
  input  logic [2*DATA_W-1:0] ram_rdata,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    out_data,
  output logic                out_last,
  output logic                busy
);

  localparam int FW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FW-1:0] SLOT_FREE = FW'(VALS_PER_SLOT);
  localparam logic [4:0] LAST_IDX = 5'(VALS_PER_SLOT - 1);

  state_t             state;
  state_t             state_nxt;
  logic               calc_busy;
  logic               hold;
  logic [SLOT_AW-1:0] slot;
  logic [4:0]         cap_cnt;
  logic               accept;
  logic               push;
  logic               pop;
  logic [DATA_W-1:0]  half;
  logic [OUT_W-1:0]   val;
  logic [OUT_W:0]     rdata;
  logic               full;
  logic               empty;
  logic [FW-1:0]      free;

  assign hold = calc_start || calc_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calc_busy <= 1'b0;
    end else if (calc_start) begin
      calc_busy <= 1'b1;
    end else if (calc_finish) begin
      calc_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      slot    <= '0;
      cap_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (accept) slot <= req_slot;
      if (state == ISSUE && !hold) cap_cnt <= '0;
      else if (state == CAPTURE) cap_cnt <= cap_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    accept    = 1'b0;
    read      = 1'b0;
    push      = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = rst_n && !hold && (free >= SLOT_FREE);
        accept    = req_valid && req_ready;
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        // A controller run in flight owns in_addr; re-pulse once it ends.
        if (!hold) begin
          read      = 1'b1;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        push = 1'b1;
        if (cap_cnt == LAST_IDX) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_addr = slot;
  assign busy    = (state != IDLE);

  assign half = sel_upper ? ram_rdata[2*DATA_W-1:DATA_W]
                          : ram_rdata[DATA_W-1:0];

`ifdef RESULT_DRAIN_SAT_EN
  logic [63:0] sat_w;
  assign sat_w = saturate(64'($signed(half)), OUT_W);
  assign val   = sat_w[OUT_W-1:0];
`else
  assign val = half[OUT_W-1:0];
`endif

  result_fifo #(
    .WIDTH (OUT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({cap_cnt == LAST_IDX, val}),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .free  (free)
  );

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = rdata[OUT_W-1:0];
  assign out_last  = !empty && rdata[OUT_W];

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain (OUT_W=8, FIFO_DEPTH=32).
// Expectations follow RESULT_DRAIN_SAT_EN when it is defined.
`timescale 1ns/1ps
module tb_result_drain;

  localparam int DW = 16;
  localparam int OW = 8;
  localparam int FD = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [4:0]    req_slot = '0;
  logic          calc_start = 1'b0;
  logic          calc_finish = 1'b0;
  logic          read;
  logic [4:0]    rd_addr;
  logic          sel_upper = 1'b0;
  logic [2*DW-1:0] ram_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          busy;

  always #5 clk = ~clk;

  result_drain #(
    .DATA_W (DW),
    .OUT_W (OW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk (clk),
    .rst_n (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_slot (req_slot),
    .calc_start (calc_start),
    .calc_finish (calc_finish),
    .read (read),
    .rd_addr (rd_addr),
    .sel_upper (sel_upper),
    .ram_rdata (ram_rdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: signed clamp to OW bits, or low OW bits.
  function automatic logic [OW-1:0] ref_val(input logic [DW-1:0] v);
`ifdef RESULT_DRAIN_SAT_EN
    int s;
    s = int'($signed(v));
    if (s > 2**(OW-1) - 1) return OW'(2**(OW-1) - 1);
    if (s < -(2**(OW-1))) return OW'(-(2**(OW-1)));
`endif
    return v[OW-1:0];
  endfunction

  // Controller/RAM model: 32 values follow each read pulse.
  logic [DW-1:0] vals [32];
  int ci = 32;
  initial forever begin
    @(negedge clk);
    if (ci < 32) begin
      sel_upper = ci[0];
      ram_rdata = {vals[ci | 1], vals[ci & ~1]};
      ci++;
    end
    if (read) ci = 0;
  end

  // Host ready pattern: 0 always, 1 one-of-three, 2 never, 3 random.
  int rdy_mode = 0;
  int rdy_ph = 0;
  initial forever begin
    @(posedge clk);
    #1;
    rdy_ph++;
    case (rdy_mode)
      0: out_ready = 1'b1;
      1: out_ready = (rdy_ph % 3 == 0);
      2: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Scoreboard: expected {last, data} words in order.
  logic [OW:0]   exp_q [$];
  logic [OW-1:0] got_q [$];
  logic          stall = 1'b0;
  logic [OW:0]   held = '0;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", {out_last, out_data}, held);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got %0h expected none", out_data);
        end else begin
          chk("out_word", {out_last, out_data}, exp_q.pop_front());
          got_q.push_back(out_data);
        end
      end
      stall = out_valid && !out_ready;
      held  = {out_last, out_data};
    end
  end

  task automatic load_exp();
    for (int i = 0; i < 32; i++)
      exp_q.push_back({i == 31, ref_val(vals[i])});
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic post_req(input logic [4:0] s, input int budget);
    bit acc = 0;
    req_slot  = s;
    req_valid = 1'b1;
    for (int c = 0; c < budget && !acc; c++) begin
      @(negedge clk);
      if (req_ready) acc = 1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    chk("req_accept", acc, 1);
    if (acc) load_exp();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    @(posedge clk);
    #1;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", exp_q.size() == 0 && !busy, 1);
    chk("drain_empty", out_valid, 0);
  endtask

  typedef struct {
    logic [DW-1:0] v;
    logic [OW-1:0] e;
  } vec_t;
  vec_t tbl [8];

  initial begin
    int n;
    int rc;
    bit acc;
    logic [4:0] s;

`ifdef RESULT_DRAIN_SAT_EN
    tbl[0] = '{16'h0100, 8'h7F};
    tbl[1] = '{16'hFF00, 8'h80};
    tbl[2] = '{16'h0042, 8'h42};
    tbl[3] = '{16'h7FFF, 8'h7F};
    tbl[4] = '{16'h8000, 8'h80};
    tbl[5] = '{16'h007F, 8'h7F};
    tbl[6] = '{16'hFF80, 8'h80};
    tbl[7] = '{16'hFFFF, 8'hFF};
`else
    tbl[0] = '{16'h0100, 8'h00};
    tbl[1] = '{16'hFF00, 8'h00};
    tbl[2] = '{16'h0042, 8'h42};
    tbl[3] = '{16'h7FFF, 8'hFF};
    tbl[4] = '{16'h8000, 8'h00};
    tbl[5] = '{16'h007F, 8'h7F};
    tbl[6] = '{16'hFF80, 8'h80};
    tbl[7] = '{16'hFFFF, 8'hFF};
`endif

    // Reset values
    #2;
    chk("rst_read", read, 0);
    chk("rst_addr", rd_addr, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", req_ready, 1);
    @(posedge clk);
    #1;

    // Basic drain of slot 5
    for (int i = 0; i < 32; i++) vals[i] = DW'(i);
    post_req(5'd5, 20);
    @(negedge clk);
    chk("basic_read", read, 1);
    chk("basic_addr", rd_addr, 5);
    n  = 1;
    rc = 1;
    while (busy && n < 100) begin
      @(negedge clk);
      if (busy) n++;
      if (read) rc++;
    end
    chk("basic_busy_len", n, 33);
    chk("basic_read_cnt", rc, 1);
    drain(200);

    // Back-pressure, one-of-three ready
    rdy_mode = 1;
    for (int i = 0; i < 32; i++) vals[i] = DW'($urandom);
    post_req(5'd9, 20);
    drain(400);

    // Table: saturation / truncation vectors
    rdy_mode = 0;
    for (int i = 0; i < 32; i++) vals[i] = tbl[i % 8].v;
    got_q.delete();
    post_req(5'd2, 20);
    drain(200);
    chk("tbl_count", got_q.size(), 32);
    for (int i = 0; i < 32; i++)
      if (i < got_q.size())
        chk($sformatf("tbl_%0d", i), got_q[i], tbl[i % 8].e);

    // Busy guard: calc_start blocks accept until calc_finish
    for (int i = 0; i < 32; i++) vals[i] = DW'($urandom);
    calc_start = 1'b1;
    req_valid  = 1'b1;
    req_slot   = 5'd12;
    @(negedge clk);
    chk("guard_start", req_ready, 0);
    @(posedge clk);
    #1 calc_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("guard_busy", req_ready, 0);
      chk("guard_noread", read, 0);
      @(posedge clk);
      #1;
    end
    calc_finish = 1'b1;
    @(negedge clk);
    chk("guard_fin", req_ready, 0);
    @(posedge clk);
    #1 calc_finish = 1'b0;
    @(negedge clk);
    chk("guard_accept", req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    load_exp();
    @(negedge clk);
    chk("guard_read", read, 1);
    chk("guard_addr", rd_addr, 12);
    drain(200);

    // calc_start during ISSUE holds the read pulse
    for (int i = 0; i < 32; i++) vals[i] = DW'($urandom);
    s = 5'd17;
    post_req(s, 20);
    calc_start = 1'b1;
    @(negedge clk);
    chk("hold_read0", read, 0);
    @(posedge clk);
    #1 calc_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_wait", read, 0);
      chk("hold_busy", busy, 1);
      @(posedge clk);
      #1;
    end
    calc_finish = 1'b1;
    @(negedge clk);
    chk("hold_fin", read, 0);
    @(posedge clk);
    #1 calc_finish = 1'b0;
    @(negedge clk);
    chk("hold_reissue", read, 1);
    chk("hold_addr", rd_addr, s);
    drain(200);

    // FIFO space: second request waits for a full slot of room
    rdy_mode = 2;
    for (int i = 0; i < 32; i++) vals[i] = DW'($urandom);
    post_req(5'd20, 20);
    req_slot  = 5'd21;
    req_valid = 1'b1;
    n   = 0;
    acc = 0;
    while (!acc && n < 400) begin
      if (n == 60) rdy_mode = 0;
      if (req_ready) acc = 1;
      else begin
        @(posedge clk);
        #1;
        n++;
      end
    end
    chk("space_seen", acc, 1);
    chk("space_waited", n >= 60, 1);
    chk("space_drained", exp_q.size(), 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (acc) load_exp();
    drain(200);

    // Randomized slots, data and ready
    rdy_mode = 3;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32; i++) vals[i] = DW'($urandom);
      post_req(5'($urandom_range(0, 31)), 20);
      drain(500);
    end

    // Reset in capture cycle 10
    rdy_mode = 0;
    for (int i = 0; i < 32; i++) vals[i] = DW'($urandom);
    post_req(5'd3, 20);
    repeat (11) @(posedge clk);
    #3 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_read", read, 0);
    chk("mid_rst_addr", rd_addr, 0);
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_last", out_last, 0);
    chk("mid_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid || busy) n++;
    end
    chk("post_rst_quiet", n, 0);
    @(posedge clk);
    #1;

    // Fresh request after reset
    for (int i = 0; i < 32; i++) vals[i] = DW'($urandom);
    post_req(5'd7, 20);
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
